param_pipe_decoder: RTL and testbench
=====================================

# param_pipe_decoder

Host-to-FPGA bulk parameter path, the inbound counterpart of the ADC pipe-out stream. Consumes 16-bit words already moved from the host pipe-in FIFO into the system clock domain. Parses framed, checksummed parameter packets. Emits one parameter-write transaction per valid packet, for the OSF, PID, router, OPP, DAC and global parameter registers. Malformed traffic is dropped and counted.

## Interface
Parameters:
- N_CHAN, 8: number of addressable channels, at most 16.
- MAX_WORDS, 4: maximum data words per packet.
- TIMEOUT, 1024: idle cycles allowed inside a packet before it is aborted.
- W_ERR, 8: error counter width.

Ports:
- clk50_in, in, 1: system clock; the only clock.
- reset_in, in, 1: synchronous, active-high reset.
- data_in, in, 16: stream word from the pipe-in FIFO.
- data_valid_in, in, 1: data_in is valid.
- data_ready_out, out, 1: the decoder accepts a word this cycle.
- wr_valid_out, out, 1: a write transaction is pending.
- wr_ready_in, in, 1: the consumer accepts the pending write.
- wr_target_out, out, 4: target module code.
- wr_chan_out, out, 4: channel index.
- wr_len_out, out, 3: number of data words, 1..MAX_WORDS.
- wr_data_out, out, 16*MAX_WORDS: packed payload.
- err_frame_count_out, out, W_ERR: saturating count of sync, length, channel and timeout errors.
- err_csum_count_out, out, W_ERR: saturating count of checksum errors.

## Operation
- A word is accepted when data_valid_in and data_ready_out are both high.
- Packet format:
  - Header word: [15:12]=4'hC (sync), [11:8]=target, [7:4]=channel, [3:0]=length.
  - Then length data words.
  - Then one checksum word equal to the XOR of the header and all data words.
- FSM states: HDR, DATA, CSUM, OUT.
- HDR:
  - A header is rejected when the sync nibble is not 4'hC, the length is 0 or greater than MAX_WORDS, or the channel is N_CHAN or higher.
  - A rejected header is dropped, err_frame is incremented, and the FSM stays in HDR. This gives word-by-word resync.
  - A good header latches target, channel and length, seeds the running XOR, clears the payload register and goes to DATA.
- DATA:
  - Data word k (0-based) is stored in wr_data_out[16k +: 16]; unused upper words read 0.
  - The word is XORed into the running checksum.
  - After word length-1 the FSM goes to CSUM.
- CSUM:
  - On a match the FSM goes to OUT.
  - On a mismatch err_csum is incremented, the packet is discarded, and the FSM returns to HDR.
- OUT:
  - wr_valid_out=1 and data_ready_out=0.
  - All wr_* outputs are held stable until wr_ready_in is high, then the FSM returns to HDR.
- Timeout counter:
  - Active in DATA and CSUM; cleared on every accepted word.
  - When it reaches TIMEOUT-1 with no accepted word, the packet is aborted, err_frame is incremented, and the FSM goes to HDR.
- Error counters saturate at all-ones; they are cleared only by reset.
- Target codes: 0 global, 1 OSF, 2 PID, 3 RTR, 4 OPP, 5 DAC. Other codes pass through unchecked.

## Timing
- Reset values:
  - data_ready_out is 0 while reset_in is high.
  - All other outputs are 0; the FSM is in HDR.
  - data_ready_out is 1 in the first cycle after reset deasserts.
- data_ready_out is a decode of the state: 1 in HDR, DATA and CSUM; 0 in OUT and during reset.
- Full throughput: one word per cycle in HDR, DATA and CSUM, with no bubbles between packets except the OUT cycles.
- wr_valid_out rises in the cycle after the checksum word is accepted (1-cycle latency).
- A write with wr_ready_in already high occupies exactly one OUT cycle. The next header can be accepted in the following cycle.
- In OUT, data_valid_in is ignored and no word is consumed.
- A reset mid-packet discards the packet, clears the counters and returns the FSM to HDR.
- A counter increment at saturation leaves the counter unchanged.

## Structure
- Shared package param_pipe_pkg holds:
  - The SYNC_NIBBLE constant (4'hC).
  - The FSM state enum.
  - The target code constants.
  - The header field bit positions.
- Sub-module sat_counter (parameters W and enable; synchronous clear) is instantiated twice for the error counters.

## Test plan
- **Valid packet:** words C212, 1234, ABCD, 7BEB with wr_ready_in=1.
  - wr_valid_out pulses for 1 cycle, the cycle after 7BEB is accepted.
  - Outputs: target=2, chan=1, len=2, wr_data_out=0x00000000ABCD1234.
- **Bad checksum:** the same packet with checksum 7BEA.
  - No wr_valid_out; err_csum=1.
  - An immediately following valid packet is accepted normally.
- **Bad headers:** words 1234, C210, C0A1 in HDR (N_CHAN=8).
  - Each word is dropped; err_frame=3.
  - data_ready_out stays 1 throughout.
- **Backpressure:** a valid packet with wr_ready_in held low for 5 cycles.
  - wr_valid_out and the wr_* outputs stay stable; data_ready_out stays 0.
  - wr_ready_in goes high: the next cycle shows data_ready_out=1 and a new header is accepted.
- **Timeout:** header C212 and word 1234, then data_valid_in=0 for TIMEOUT cycles.
  - Abort; err_frame=1; FSM in HDR.
  - A later valid packet decodes correctly.
- **Saturation and reset:**
  - 300 bad headers give err_frame=255.
  - Asserting reset_in after the header and first data word of a packet clears both counters and wr_valid_out; no stale write is emitted.

Source files
------------

// File: rtl/param_pipe_pkg.sv
// Shared definitions for the host-to-FPGA parameter packet decoder:
// sync value, FSM states, target codes and header field positions.
package param_pipe_pkg;

  localparam logic [3:0] SYNC_NIBBLE = 4'hC;

  typedef enum logic [1:0] {HDR, DATA, CSUM, OUT} state_t;

  localparam logic [3:0] TGT_GLOBAL = 4'd0;
  localparam logic [3:0] TGT_OSF    = 4'd1;
  localparam logic [3:0] TGT_PID    = 4'd2;
  localparam logic [3:0] TGT_RTR    = 4'd3;
  localparam logic [3:0] TGT_OPP    = 4'd4;
  localparam logic [3:0] TGT_DAC    = 4'd5;

  // Header word: [15:12] sync, [11:8] target, [7:4] channel, [3:0] length
  localparam int SYNC_LSB = 12;
  localparam int TGT_LSB  = 8;
  localparam int CHAN_LSB = 4;
  localparam int LEN_LSB  = 0;
  localparam int FIELD_W  = 4;

endpackage

// File: rtl/param_pipe_decoder_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr)                        count <= '0;
    else if (en && (count != '1))   count <= count + 1'b1;
  end

endmodule

// File: rtl/param_pipe_decoder.sv
// Parses framed, XOR-checksummed parameter packets from the pipe-in stream
// and emits one write transaction per good packet; bad traffic is counted.
module param_pipe_decoder
  import param_pipe_pkg::*;
#(
  parameter int N_CHAN    = 8,
  parameter int MAX_WORDS = 4,
  parameter int TIMEOUT   = 1024,
  parameter int W_ERR     = 8
) (
  input  logic                   clk50_in,
  input  logic                   reset_in,
  input  logic [15:0]            data_in,
  input  logic                   data_valid_in,
  output logic                   data_ready_out,
  output logic                   wr_valid_out,
  input  logic                   wr_ready_in,
  output logic [3:0]             wr_target_out,
  output logic [3:0]             wr_chan_out,
  output logic [2:0]             wr_len_out,
  output logic [16*MAX_WORDS-1:0] wr_data_out,
  output logic [W_ERR-1:0]       err_frame_count_out,
  output logic [W_ERR-1:0]       err_csum_count_out
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t                       state, state_nxt;
  logic [3:0]                   tgt_q, chan_q;
  logic [2:0]                   len_q, idx;
  logic [15:0]                  csum;
  logic [MAX_WORDS-1:0][15:0]   data_q;
  logic [TW-1:0]                timer;
  logic [FIELD_W-1:0]           h_sync, h_tgt, h_chan, h_len;
  logic                         accept, hdr_ok, timeout, last_word;
  logic                         frame_err, csum_err;

  assign h_sync = data_in[SYNC_LSB +: FIELD_W];
  assign h_tgt  = data_in[TGT_LSB  +: FIELD_W];
  assign h_chan = data_in[CHAN_LSB +: FIELD_W];
  assign h_len  = data_in[LEN_LSB  +: FIELD_W];

  assign hdr_ok = (h_sync == SYNC_NIBBLE) && (h_len != '0) &&
                  (int'(h_len) <= MAX_WORDS) && (int'(h_chan) < N_CHAN);

  assign data_ready_out = !reset_in && (state != OUT);
  assign accept         = data_valid_in && data_ready_out;
  assign last_word      = (idx == len_q - 3'd1);
  assign timeout        = ((state == DATA) || (state == CSUM)) && !accept &&
                          (timer == TW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    frame_err = 1'b0;
    csum_err  = 1'b0;
    case (state)
      HDR: if (accept) begin
        if (hdr_ok) state_nxt = DATA;
        else        frame_err = 1'b1;   // drop and stay: word-by-word resync
      end
      DATA: begin
        if (accept && last_word) state_nxt = CSUM;
        else if (timeout) begin
          state_nxt = HDR;
          frame_err = 1'b1;
        end
      end
      CSUM: begin
        if (accept) begin
          if (data_in == csum) state_nxt = OUT;
          else begin
            state_nxt = HDR;
            csum_err  = 1'b1;
          end
        end else if (timeout) begin
          state_nxt = HDR;
          frame_err = 1'b1;
        end
      end
      OUT:     if (wr_ready_in) state_nxt = HDR;
      default: state_nxt = HDR;
    endcase
  end

  always_ff @(posedge clk50_in) begin
    if (reset_in) begin
      state  <= HDR;
      tgt_q  <= '0;
      chan_q <= '0;
      len_q  <= '0;
      idx    <= '0;
      csum   <= '0;
      data_q <= '0;
      timer  <= '0;
    end else begin
      state <= state_nxt;
      if ((state == DATA) || (state == CSUM)) timer <= accept ? '0 : timer + 1'b1;
      else                                    timer <= '0;
      case (state)
        HDR: if (accept && hdr_ok) begin
          tgt_q  <= h_tgt;
          chan_q <= h_chan;
          len_q  <= h_len[2:0];
          idx    <= '0;
          csum   <= data_in;
          data_q <= '0;
        end
        DATA: if (accept) begin
          for (int k = 0; k < MAX_WORDS; k++)
            if (idx == 3'(k)) data_q[k] <= data_in;
          csum <= csum ^ data_in;
          idx  <= idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign wr_valid_out  = !reset_in && (state == OUT);
  assign wr_target_out = tgt_q;
  assign wr_chan_out   = chan_q;
  assign wr_len_out    = len_q;
  assign wr_data_out   = data_q;

  sat_counter #(.W(W_ERR)) u_err_frame (
    .clk   (clk50_in),
    .clr   (reset_in),
    .en    (frame_err),
    .count (err_frame_count_out)
  );

  sat_counter #(.W(W_ERR)) u_err_csum (
    .clk   (clk50_in),
    .clr   (reset_in),
    .en    (csum_err),
    .count (err_csum_count_out)
  );

endmodule

// File: tb/tb_param_pipe_decoder.sv
// Scoreboard bench for param_pipe_decoder: expected writes are queued as
// packets are driven and compared when the DUT completes a write handshake.
module tb_param_pipe_decoder;

  localparam int N_CHAN    = 8;
  localparam int MAX_WORDS = 4;
  localparam int TIMEOUT   = 1024;
  localparam int W_ERR     = 8;

  typedef struct {
    logic [3:0]  tgt;
    logic [3:0]  chan;
    logic [2:0]  len;
    logic [63:0] data;
  } wr_t;

  logic        clk50 = 1'b0;
  logic        reset_in = 1'b1;
  logic [15:0] data_in = '0;
  logic        data_valid_in = 1'b0;
  logic        data_ready_out;
  logic        wr_valid_out;
  logic        wr_ready_in = 1'b1;
  logic [3:0]  wr_target_out, wr_chan_out;
  logic [2:0]  wr_len_out;
  logic [63:0] wr_data_out;
  logic [7:0]  err_frame_count_out, err_csum_count_out;

  int  n_chk = 0, n_err = 0, n_wr = 0;
  int  last_wait, hdr_wait, wr_snap;
  wr_t exp_q[$];
  wr_t mon_e;

  always #5 clk50 = ~clk50;

  param_pipe_decoder #(
    .N_CHAN(N_CHAN), .MAX_WORDS(MAX_WORDS), .TIMEOUT(TIMEOUT), .W_ERR(W_ERR)
  ) dut (
    .clk50_in            (clk50),
    .reset_in            (reset_in),
    .data_in             (data_in),
    .data_valid_in       (data_valid_in),
    .data_ready_out      (data_ready_out),
    .wr_valid_out        (wr_valid_out),
    .wr_ready_in         (wr_ready_in),
    .wr_target_out       (wr_target_out),
    .wr_chan_out         (wr_chan_out),
    .wr_len_out          (wr_len_out),
    .wr_data_out         (wr_data_out),
    .err_frame_count_out (err_frame_count_out),
    .err_csum_count_out  (err_csum_count_out)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop and compare on every completed write handshake
  always @(negedge clk50) begin
    if (!reset_in && wr_valid_out && wr_ready_in) begin
      n_wr++;
      if (exp_q.size() == 0) chk("unexpected_wr", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("wr_target", wr_target_out, mon_e.tgt);
        chk("wr_chan",   wr_chan_out,   mon_e.chan);
        chk("wr_len",    wr_len_out,    mon_e.len);
        chk("wr_data",   wr_data_out,   mon_e.data);
      end
    end
  end

  task automatic send_word(input logic [15:0] w);
    int t = 0;
    data_in = w;
    data_valid_in = 1'b1;
    @(negedge clk50);
    while (!data_ready_out && t < 100) begin
      @(negedge clk50);
      t++;
    end
    last_wait = t;
    if (t >= 100) chk("ready_wait_expired", 0, 1);
    @(posedge clk50); #1;
    data_valid_in = 1'b0;
  endtask

  task automatic send_pkt(input logic [3:0] tgt, input logic [3:0] chan, input int n,
                          input logic [63:0] payload, input bit bad_cs);
    logic [15:0] h, cs;
    wr_t e;
    h  = {4'hC, tgt, chan, 4'(n)};
    cs = h;
    send_word(h);
    hdr_wait = last_wait;
    for (int k = 0; k < n; k++) begin
      cs ^= payload[16*k +: 16];
      send_word(payload[16*k +: 16]);
    end
    if (bad_cs) cs ^= 16'h0001;
    else begin
      e.tgt = tgt; e.chan = chan; e.len = 3'(n); e.data = payload;
      exp_q.push_back(e);
    end
    send_word(cs);
  endtask

  task automatic do_reset();
    data_valid_in = 1'b0;
    reset_in = 1'b1;
    @(negedge clk50);
    chk("rst_ready", data_ready_out, 0);
    @(posedge clk50); #1;
    @(negedge clk50);
    chk("rst_valid",     wr_valid_out, 0);
    chk("rst_err_frame", err_frame_count_out, 0);
    chk("rst_err_csum",  err_csum_count_out, 0);
    @(posedge clk50); #1;
    reset_in = 1'b0;
    @(negedge clk50);
    chk("post_rst_ready", data_ready_out, 1);
    @(posedge clk50); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_data", wr_data_out, 0);
    chk("rst_tgt",  wr_target_out, 0);

    // Valid packet with 1-cycle write pulse
    send_pkt(4'd2, 4'd1, 2, 64'h0000_0000_ABCD_1234, 1'b0);
    @(negedge clk50);
    chk("t1_valid_lat", wr_valid_out, 1);
    chk("t1_ready_out", data_ready_out, 0);
    @(negedge clk50);
    chk("t1_pulse_end", wr_valid_out, 0);
    chk("t1_ready_back", data_ready_out, 1);
    @(posedge clk50); #1;

    // Bad checksum, then an immediate good packet
    do_reset();
    wr_snap = n_wr;
    send_pkt(4'd2, 4'd1, 2, 64'h0000_0000_ABCD_1234, 1'b1);
    @(negedge clk50);
    chk("t2_no_valid", wr_valid_out, 0);
    chk("t2_err_csum", err_csum_count_out, 1);
    chk("t2_no_wr", n_wr, wr_snap);
    @(posedge clk50); #1;
    send_pkt(4'd4, 4'd3, 1, 64'h0000_0000_0000_BEEF, 1'b0);
    repeat (2) @(posedge clk50); #1;
    chk("t2_good_after", n_wr, wr_snap + 1);

    // Bad headers: bad sync, zero length, channel out of range
    do_reset();
    send_word(16'h1234); chk("t3_ready0", data_ready_out, 1);
    send_word(16'hC210); chk("t3_ready1", data_ready_out, 1);
    send_word(16'hC0A1); chk("t3_ready2", data_ready_out, 1);
    send_word(16'hC215);   // length above MAX_WORDS
    @(negedge clk50);
    chk("t3_err_frame", err_frame_count_out, 4);
    chk("t3_err_csum",  err_csum_count_out, 0);
    @(posedge clk50); #1;

    // Backpressure: held write stays stable, then resume without a bubble
    do_reset();
    wr_ready_in = 1'b0;
    send_pkt(4'd5, 4'd7, 4, 64'h1111_2222_3333_4444, 1'b0);
    repeat (5) begin
      @(negedge clk50);
      chk("bp_valid", wr_valid_out, 1);
      chk("bp_ready", data_ready_out, 0);
      chk("bp_tgt",   wr_target_out, 4'd5);
      chk("bp_chan",  wr_chan_out, 4'd7);
      chk("bp_len",   wr_len_out, 3'd4);
      chk("bp_data",  wr_data_out, 64'h1111_2222_3333_4444);
    end
    @(posedge clk50); #1;
    wr_ready_in = 1'b1;
    send_pkt(4'd0, 4'd0, 3, 64'h0000_0003_0002_0001, 1'b0);
    chk("bp_resume_wait", hdr_wait, 1);
    repeat (2) @(posedge clk50); #1;

    // Timeout inside a packet, checked one cycle before and at the limit
    do_reset();
    wr_snap = n_wr;
    send_word(16'hC212);
    send_word(16'h1234);
    repeat (TIMEOUT - 1) @(posedge clk50); #1;
    chk("to_not_yet", err_frame_count_out, 0);
    @(posedge clk50); #1;
    chk("to_err_frame", err_frame_count_out, 1);
    chk("to_ready", data_ready_out, 1);
    chk("to_no_wr", n_wr, wr_snap);
    send_pkt(4'd1, 4'd6, 2, 64'h0000_0000_5678_9ABC, 1'b0);
    repeat (2) @(posedge clk50); #1;
    chk("to_good_after", n_wr, wr_snap + 1);

    // Saturation, then reset mid-packet
    do_reset();
    for (int i = 0; i < 300; i++) send_word(16'h1234);
    chk("sat_err_frame", err_frame_count_out, 255);
    wr_snap = n_wr;
    send_word(16'hC212);
    send_word(16'h1234);
    reset_in = 1'b1;
    @(negedge clk50);
    chk("mid_rst_ready", data_ready_out, 0);
    @(posedge clk50); #1;
    chk("mid_rst_frame", err_frame_count_out, 0);
    chk("mid_rst_csum",  err_csum_count_out, 0);
    chk("mid_rst_valid", wr_valid_out, 0);
    reset_in = 1'b0;
    repeat (5) @(posedge clk50); #1;
    chk("mid_rst_no_wr", n_wr, wr_snap);
    chk("mid_rst_valid2", wr_valid_out, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
